// File: rtl/mcycle_issue_if.sv
// Request/response and multi-cycle-unit signals of the issue controller.
// slave is the controller's view; master is the environment (requester, consumer and unit).
interface mcycle_issue_if #(
  parameter int width = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [width-1:0] req_a;
  logic [width-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [width-1:0] rsp_data;
  logic             rsp_err;
  logic             mc_start;
  logic             mc_op;
  logic [width-1:0] mc_op1;
  logic [width-1:0] mc_op2;
  logic [width-1:0] mc_result;
  logic             mc_busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, mc_result, mc_busy,
    output req_ready, rsp_valid, rsp_data, rsp_err, mc_start, mc_op, mc_op1, mc_op2
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, mc_result, mc_busy,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mc_start, mc_op, mc_op1, mc_op2
  );
endinterface

// File: rtl/mcycle_issue.sv
// Issues multiply/divide requests to a multi-cycle unit, with a one-entry result cache,
// divide-by-zero short-circuit and a RUN timeout.
//
//   state | meaning
//   IDLE  | ready for a request
//   RUN   | unit started, waiting for busy to rise and fall (or timeout)
//   RESP  | response presented until consumer accepts it
module mcycle_issue #(
  parameter int width   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mcycle_issue_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             op_q;
  logic [width-1:0] a_q, b_q;
  logic             cache_valid, cache_op;
  logic [width-1:0] cache_a, cache_b, cache_res;
  logic [width-1:0] data_q;
  logic             err_q;
  logic             seen_busy;
  logic [CW-1:0]    cnt;
  logic             ready, accept, div0, hit, done, tmo, start;

  always_comb begin
    ready  = (state == IDLE) && rst_n;
    accept = bus.req_valid && ready;
    div0   = bus.req_op && (bus.req_b == '0);
    hit    = cache_valid && (cache_op == bus.req_op) && (cache_a == bus.req_a) &&
             (cache_b == bus.req_b);
    done   = (state == RUN) && seen_busy && !bus.mc_busy;
    tmo    = (state == RUN) && (cnt == CW'(TIMEOUT - 1));
    // Dropping start in the done cycle keeps the unit from being re-triggered.
    start  = (state == RUN) && !done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (div0 || hit) ? RESP : RUN;
      RUN:     if (done || tmo) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cache_valid <= 1'b0;
      cache_op    <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_res   <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      seen_busy   <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        op_q      <= bus.req_op;
        a_q       <= bus.req_a;
        b_q       <= bus.req_b;
        seen_busy <= 1'b0;
        cnt       <= '0;
        if (div0) begin
          data_q <= '1;
          err_q  <= 1'b1;
        end else if (hit) begin
          data_q <= cache_res;
          err_q  <= 1'b0;
        end
      end
      if (state == RUN) begin
        if (bus.mc_busy) seen_busy <= 1'b1;
        cnt <= cnt + 1'b1;
        // Done takes priority over a timeout landing in the same cycle.
        if (done) begin
          data_q      <= bus.mc_result;
          err_q       <= 1'b0;
          cache_valid <= 1'b1;
          cache_op    <= op_q;
          cache_a     <= a_q;
          cache_b     <= b_q;
          cache_res   <= bus.mc_result;
        end else if (tmo) begin
          data_q      <= '0;
          err_q       <= 1'b1;
          cache_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.mc_start  = start;
  assign bus.mc_op     = op_q;
  assign bus.mc_op1    = a_q;
  assign bus.mc_op2    = b_q;
endmodule

// File: tb/tb_mcycle_issue.sv
// Directed and random requests against a request-level reference model and a
// behavioural multi-cycle unit whose busy time and failure mode are set per request.
module tb_mcycle_issue;
  localparam int TIMEOUT = 255;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mcycle_issue_if #(.width(32)) bus ();

  mcycle_issue #(.width(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unit model: mode 0 = busy for busy_len cycles then result, 1 = busy stuck, 2 = never busy.
  int          mode;
  int          busy_len;
  int          starts;
  bit          active;
  int          ucnt;
  logic [31:0] u_a, u_b;
  logic        u_op;

  initial begin
    bus.mc_busy   = 1'b0;
    bus.mc_result = '0;
    active = 0;
    starts = 0;
    ucnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mc_start && !active) begin
        active = 1;
        starts++;
        ucnt = 0;
        u_op = bus.mc_op;
        u_a  = bus.mc_op1;
        u_b  = bus.mc_op2;
        if (mode != 2) bus.mc_busy = 1'b1;
      end else if (active) begin
        if (!bus.mc_start) begin
          active      = 0;
          bus.mc_busy = 1'b0;
        end else if (mode == 0) begin
          ucnt++;
          if (ucnt == busy_len) begin
            bus.mc_busy   = 1'b0;
            bus.mc_result = u_op ? (u_a / u_b) : (u_a * u_b);
          end
        end
      end
    end
  end

  // Request-level reference: a single cached {op, a, b, result} entry.
  bit          c_valid;
  logic        c_op;
  logic [31:0] c_a, c_b, c_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int mode_i, input int blen, input int hold);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat, exp_hi, exp_starts, n, hi, ready_seen, starts0;
    if (op && b == 0) begin
      exp_data = '1; exp_err = 1'b1; exp_lat = 1; exp_hi = 0; exp_starts = 0;
    end else if (c_valid && c_op == op && c_a == a && c_b == b) begin
      exp_data = c_res; exp_err = 1'b0; exp_lat = 1; exp_hi = 0; exp_starts = 0;
    end else if (mode_i != 0) begin
      exp_data = '0; exp_err = 1'b1; exp_lat = TIMEOUT + 1; exp_hi = TIMEOUT; exp_starts = 1;
      c_valid = 0;
    end else begin
      exp_data = op ? (a / b) : (a * b);
      exp_err = 1'b0; exp_lat = blen + 2; exp_hi = blen; exp_starts = 1;
      c_valid = 1; c_op = op; c_a = a; c_b = b; c_res = exp_data;
    end
    mode     = mode_i;
    busy_len = blen;
    starts0  = starts;

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    n = 0; hi = 0; ready_seen = 0;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("mc_op", bus.mc_op, op);
        chk("mc_op1", bus.mc_op1, a);
        chk("mc_op2", bus.mc_op2, b);
      end
      if (bus.rsp_valid) break;
      if (bus.mc_start) hi++;
      if (bus.req_ready) ready_seen++;
    end
    chk("rsp_valid_seen", bus.rsp_valid, 1);
    chk("latency", n, exp_lat);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("start_cycles", hi, exp_hi);
    chk("unit_starts", starts - starts0, exp_starts);
    chk("ready_in_run", ready_seen, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, exp_data);
      chk("hold_err", bus.rsp_err, exp_err);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_released", bus.rsp_valid, 0);
    chk("ready_after_rsp", bus.req_ready, 1);
  endtask

  initial begin
    logic        r_op, p_op;
    logic [31:0] r_a, r_b, p_a, p_b;
    bit          have_prev;
    checks = 0; errors = 0;
    mode = 0; busy_len = 1;
    c_valid = 0; have_prev = 0;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mc_start", bus.mc_start, 0);
    chk("rst_mc_op", bus.mc_op, 0);
    chk("rst_mc_op1", bus.mc_op1, 0);
    chk("rst_mc_op2", bus.mc_op2, 0);
    rst_n = 1'b1;

    issue(1'b0, 32'd6, 32'd3, 0, 4, 0);
    issue(1'b1, 32'd6, 32'd3, 0, 2, 0);
    issue(1'b1, 32'd6, 32'd3, 0, 2, 0);
    issue(1'b1, 32'hFCDEFFFD, 32'd0, 0, 2, 0);
    issue(1'b0, 32'hFCDEFFFF, 32'hFAFFFFFF, 1, 0, 0);
    issue(1'b0, 32'hFCDEFFFF, 32'hFAFFFFFF, 0, 3, 0);
    issue(1'b0, 32'd5, 32'd5, 0, 2, 10);
    issue(1'b1, 32'd100, 32'd7, 2, 0, 0);
    issue(1'b0, 32'd7, 32'd9, 0, 2, 0);

    // Abort a RUN with reset; cached 7x9 must be forgotten afterwards.
    mode = 0; busy_len = 8;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_a = 32'd11; bus.req_b = 32'd13;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_start_before_rst", bus.mc_start, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_run_mc_start", bus.mc_start, 0);
    chk("rst_run_req_ready", bus.req_ready, 0);
    chk("rst_run_rsp_valid", bus.rsp_valid, 0);
    chk("rst_run_mc_op1", bus.mc_op1, 0);
    c_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", bus.req_ready, 1);
    @(negedge clk);
    chk("rel_no_rsp", bus.rsp_valid, 0);
    issue(1'b0, 32'd7, 32'd9, 0, 3, 0);

    for (int i = 0; i < 30; i++) begin
      if (have_prev && $urandom_range(0, 9) < 3) begin
        r_op = p_op; r_a = p_a; r_b = p_b;
      end else begin
        r_op = 1'($urandom_range(0, 1));
        r_a  = $urandom;
        if ($urandom_range(0, 5) == 0) r_b = '0;
        else if (r_op) r_b = $urandom_range(1, 1000);
        else r_b = $urandom;
      end
      issue(r_op, r_a, r_b, 0, $urandom_range(1, 6), $urandom_range(0, 3));
      p_op = r_op; p_a = r_a; p_b = r_b; have_prev = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcycle_issue.md
MCYCLE_ISSUE -- requirements
Module: mcycle_issue

Interface
REQ-001 Parameter: width, default 32, width of operands and result.
REQ-002 Parameter: TIMEOUT, default 255, maximum cycles spent in RUN before abort.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  1  0 = multiply, 1 = divide.
REQ-008 req_a  input  width  operand 1.
REQ-009 req_b  input  width  operand 2.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_data  output  width  result.
REQ-013 rsp_err  output  1  1 = divide-by-zero or timeout.
REQ-014 mc_start  output  1  Start to multi-cycle unit.
REQ-015 mc_op  output  1  MCycleOp to multi-cycle unit.
REQ-016 mc_op1, mc_op2  output  width  Operand1/Operand2 to multi-cycle unit.
REQ-017 mc_result  input  width  Result from multi-cycle unit.
REQ-018 mc_busy  input  1  Busy from multi-cycle unit.

Function
REQ-019 FSM states IDLE, RUN, RESP; req_ready SHALL be 1 only in IDLE; no overlap of request and response.
REQ-020 Accept on req_valid & req_ready: op, a, b latched into internal registers; mc_op/mc_op1/mc_op2 driven from these registers and stable until next accept.
REQ-021 Accept with op=1 and b=0: next state RESP, rsp_data = all ones, rsp_err = 1, mc_start never asserted.
REQ-022 Accept matching cache (cache_valid, same op, a, b): next state RESP, rsp_data = cached result, rsp_err = 0, mc_start never asserted.
REQ-023 Otherwise next state RUN; mc_start high from the cycle after accept.
REQ-024 seen_busy cleared on RUN entry, set when mc_busy sampled 1 in RUN; done = RUN & seen_busy & ~mc_busy.
REQ-025 mc_start = RUN & ~done (combinational), so Start is low in the done cycle and the unit is never restarted.
REQ-026 On done edge: rsp_data <= mc_result verbatim, rsp_err <= 0, cache <= {op, a, b, result}, cache_valid <= 1, next state RESP.
REQ-027 Cycle counter cleared on RUN entry, increments each RUN cycle; counter reaching TIMEOUT without done: next state RESP, rsp_data = 0, rsp_err = 1, cache_valid <= 0.
REQ-028 mc_busy never seen high counts toward timeout; mc_busy ignored in IDLE and RESP.
REQ-029 RESP: rsp_valid = 1, rsp_data/rsp_err held stable until rsp_valid & rsp_ready, then IDLE.
REQ-030 Latency: cache hit or div-by-zero, rsp_valid 1 cycle after accept; issued op, rsp_valid 1 cycle after done.
REQ-031 Done and timeout in the same cycle: done wins, rsp_err = 0.

Reset
REQ-032 RESET low SHALL immediately force IDLE, req_ready = 0 while low, rsp_valid = 0, rsp_data = 0, rsp_err = 0, mc_start = 0, mc_op = 0, mc_op1 = mc_op2 = 0, cache_valid = 0, counter = 0.
REQ-033 Reset mid-RUN SHALL drop mc_start asynchronously; in-flight result discarded; req_ready = 1 the first cycle after RESET released.

Verification
REQ-034 Mul 6 x 3, model asserts Busy 4 cycles then returns 18 -> mc_start high until done cycle, rsp_data = 18, rsp_err = 0.
REQ-035 Div 6 / 3 model returns 2, then same request again -> second response 1 cycle after accept, rsp_data = 2, mc_start stays 0.
REQ-036 Div 0xFCDEFFFD / 0 -> rsp_data = 0xFFFFFFFF, rsp_err = 1, mc_start never high.
REQ-037 Mul 0xFCDEFFFF x 0xFAFFFFFF, mc_busy stuck 1 -> abort after 255 RUN cycles, rsp_data = 0, rsp_err = 1, following identical request issues to the unit again (cache invalid).
REQ-038 rsp_ready held 0 for 10 cycles after response -> rsp_valid and rsp_data stable throughout, req_ready = 0 until handshake.
REQ-039 RESET low 3 cycles into a RUN -> mc_start low same cycle, no response issued, new request accepted right after release.
